// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start(0), data LSB first, parity, stop(1).
// Words arrive over a valid/ready handshake; one frame in flight at a time.
module parity_frame_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          ODD          = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic              parity_out
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   baud_q, baud_d;
  logic [IdxW-1:0]   bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              bit_end;

  assign bit_end = (baud_q == BaudLast);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    parity_d  = parity_q;
    done_d    = 1'b0;
    tx_d      = 1'b1;

    if (state_q != StIdle) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d   = StStart;
          shreg_d   = data_in;
          parity_d  = ODD ? ~^data_in : ^data_in;
          baud_d    = '0;
          bit_idx_d = '0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_idx_q == IdxLast) begin
            state_d   = StParity;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // tx is registered from next-state values so it lines up with state_q.
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shreg_d[bit_idx_d];
      StParity: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign busy       = ~in_ready;
  assign tx         = tx_q;
  assign done       = done_q;
  assign parity_out = parity_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed bench for parity_frame_tx: odd-parity and even-parity instances
// share the stimulus; each frame's tx waveform is captured and compared whole.
module tb_parity_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] data_in;
  logic       in_ready, tx, busy, done, parity_out;
  logic       e_in_ready, e_tx, e_busy, e_done, e_parity_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  parity_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .ODD(1'b1)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .done       (done),
    .parity_out (parity_out)
  );

  parity_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .ODD(1'b0)) u_dut_even (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .in_valid   (in_valid),
    .in_ready   (e_in_ready),
    .tx         (e_tx),
    .busy       (e_busy),
    .done       (e_done),
    .parity_out (e_parity_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected tx per cycle for a 44-cycle frame, 4 cycles per bit.
  function automatic logic [63:0] frame_vec(input logic [7:0] d, input logic p);
    logic [63:0] v;
    int b;
    v = '0;
    for (int k = 0; k < 44; k++) begin
      b = k / 4;
      if (b == 0)       v[k] = 1'b0;
      else if (b <= 8)  v[k] = d[b-1];
      else if (b == 9)  v[k] = p;
      else              v[k] = 1'b1;
    end
    return v;
  endfunction

  task automatic start_hs(input logic [7:0] d);
    @(negedge clk);
    data_in  = d;
    in_valid = 1'b1;
    check("ready_before_hs", {63'd0, in_ready}, 64'd1);
  endtask

  // Covers the capture edge, the 44 frame cycles and the done cycle.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic par,
                           input bit hold, input logic [7:0] next_d, input int glitch_k,
                           output logic [63:0] txv);
    logic [63:0] etxv, dv;
    txv  = '0;
    etxv = '0;
    dv   = '0;
    @(posedge clk);
    for (int k = 0; k <= 44; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check({tag, "_parity"}, {63'd0, parity_out}, {63'd0, par});
        check({tag, "_parity_even"}, {63'd0, e_parity_out}, {63'd0, ~par});
        check({tag, "_busy"}, {63'd0, busy}, 64'd1);
        if (!hold) in_valid = 1'b0;
      end
      if (k == glitch_k) begin
        in_valid = 1'b1;
        data_in  = 8'hFF;
      end
      if (k == glitch_k + 2) in_valid = 1'b0;
      if (k < 44) begin
        txv[k]  = tx;
        etxv[k] = e_tx;
        dv[k]   = done | e_done;
      end else begin
        check({tag, "_done"}, {62'd0, e_done, done}, 64'd3);
        check({tag, "_done_cycle_tx"}, {63'd0, tx}, 64'd1);
        check({tag, "_done_cycle_ready"}, {63'd0, in_ready}, 64'd1);
        if (hold) data_in = next_d;
      end
    end
    check({tag, "_tx_frame"}, txv, frame_vec(d, par));
    check({tag, "_tx_frame_even"}, etxv, frame_vec(d, ~par));
    check({tag, "_no_early_done"}, dv, 64'd0);
  endtask

  task automatic idle_check(input string tag, input int cycles);
    logic [1:0] seen;
    seen = 2'b00;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || e_tx !== 1'b1) seen[0] = 1'b1;
      if (done !== 1'b0 || e_done !== 1'b0 || in_ready !== 1'b1) seen[1] = 1'b1;
    end
    check(tag, {62'd0, seen}, 64'd0);
  endtask

  initial begin
    logic [63:0] txv;
    logic [7:0]  dbits;

    // 1: reset state
    rst      = 1'b1;
    in_valid = 1'b0;
    data_in  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx", {63'd0, tx}, 64'd1);
    check("rst_ready", {63'd0, in_ready}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_parity", {63'd0, parity_out}, 64'd0);
    rst = 1'b0;

    // 2: all-zero word, odd parity 1
    start_hs(8'h00);
    run_frame("f00", 8'h00, 1'b1, 1'b0, 8'h00, -10, txv);
    idle_check("idle_after_f00", 3);

    // 3: A6 then 01
    start_hs(8'hA6);
    run_frame("fA6", 8'hA6, 1'b1, 1'b0, 8'h00, -10, txv);
    for (int i = 0; i < 8; i++) dbits[i] = txv[4 * (i + 1) + 2];
    check("fA6_data_bits", {56'd0, dbits}, {56'd0, 8'b1010_0110});
    start_hs(8'h01);
    run_frame("f01", 8'h01, 1'b0, 1'b0, 8'h00, -10, txv);

    // 4: back-to-back, second capture in the done cycle
    start_hs(8'hD9);
    run_frame("fD9", 8'hD9, 1'b0, 1'b1, 8'hE8, -10, txv);
    run_frame("fE8", 8'hE8, 1'b1, 1'b0, 8'h00, -10, txv);
    idle_check("idle_after_b2b", 4);

    // 5: in_valid pulse with FF during DATA is ignored
    start_hs(8'h02);
    run_frame("f02", 8'h02, 1'b0, 1'b0, 8'h00, 14, txv);
    idle_check("no_second_frame", 50);

    // 6: reset during data bit 3 of 0E
    start_hs(8'h0E);
    @(posedge clk);
    for (int k = 0; k <= 17; k++) begin
      @(negedge clk);
      if (k == 0) in_valid = 1'b0;
    end
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", {62'd0, e_tx, tx}, 64'd3);
    check("midrst_ready", {62'd0, e_in_ready, in_ready}, 64'd3);
    check("midrst_done", {62'd0, e_done, done}, 64'd0);
    check("midrst_parity", {62'd0, e_parity_out, parity_out}, 64'd0);
    rst = 1'b0;
    idle_check("no_done_after_rst", 50);
    start_hs(8'h0E);
    run_frame("f0E", 8'h0E, 1'b0, 1'b0, 8'h00, -10, txv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
